// File: rtl/tdc_pkg.sv
// tdc_pkg: shared types and constants for the TDC hit sequencer.
//   tdc_state_e    sequencer state encoding
//   tap_w()        delay-line tap count from the number of CARRY4 stages
//   fine_w()       width of a fine code that spans 0..TAP_W
//   RST_*          reset values of the sequencer's scalar outputs and state
package tdc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_ENCODE,
        S_HOLD,
        S_DEAD,
        S_FLUSH
    } tdc_state_e;

    function automatic int tap_w(input int ncarry4);
        return 4 * ncarry4;
    endfunction

    function automatic int fine_w(input int taps_w);
        return $clog2(taps_w + 1);
    endfunction

    localparam tdc_state_e RST_STATE = S_IDLE;
    localparam logic       RST_ARM   = 1'b0;
    localparam logic       RST_VALID = 1'b0;
    localparam logic       RST_STUCK = 1'b0;

endpackage

// File: rtl/tdc_therm_encoder.sv
// tdc_therm_encoder: combinational thermometer-to-binary converter.
//   therm  in  TAP_W   latched delay-line taps, bit 0 nearest the trigger
//   fine   out FINE_W  fine code 0..TAP_W
// Build option TDC_BUBBLE_FILTER_EN:
//   undefined -> fine = popcount(therm)
//   defined   -> 3-bit majority filter (edge bits padded with themselves),
//                then fine = run length of ones starting at bit 0
module tdc_therm_encoder #(
    parameter int TAP_W  = 32,
    parameter int FINE_W = 6
) (
    input  logic [TAP_W-1:0]  therm,
    output logic [FINE_W-1:0] fine
);

`ifdef TDC_BUBBLE_FILTER_EN
    logic [TAP_W+1:0] ext;
    logic [TAP_W-1:0] filt;
    logic             run;

    // Pad each end with its own edge bit so the window never leaves the line.
    assign ext = {therm[TAP_W-1], therm, therm[0]};

    always_comb begin
        filt = '0;
        for (int i = 0; i < TAP_W; i++) begin
            filt[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
        end
    end

    always_comb begin
        fine = '0;
        run  = 1'b1;
        for (int i = 0; i < TAP_W; i++) begin
            run  = run & filt[i];
            fine = fine + FINE_W'(run);
        end
    end
`else
    always_comb begin
        fine = '0;
        for (int i = 0; i < TAP_W; i++) begin
            fine = fine + FINE_W'(therm[i]);
        end
    end
`endif

endmodule

// File: rtl/tdc_hit_sequencer.sv
// tdc_hit_sequencer: arms a carry-chain TDC, captures one hit, hands out one
// timestamp (coarse count + fine code), then enforces dead time and waits for
// the line to clear before re-arming.
//   clk, rst_n     clock, asynchronous active-low reset
//   enable         run coarse counter / allow arming
//   taps           registered delay-line outputs, bit 0 nearest the trigger
//   arm            trigger gate to the line (high only in ARMED)
//   ts_valid/ready timestamp handshake
//   ts_coarse      coarse count of the detection cycle
//   ts_fine        fine code 0..TAP_W
//   line_stuck     sticky: line failed to clear within FLUSH_MAX cycles
// Build option TDC_BUBBLE_FILTER_EN selects the fine encoder (see encoder).
module tdc_hit_sequencer
    import tdc_pkg::*;
#(
    parameter  int NCARRY4     = 8,
    parameter  int COARSE_W    = 16,
    parameter  int DEAD_CYCLES = 4,
    parameter  int FLUSH_MAX   = 16,
    localparam int TAP_W       = tap_w(NCARRY4),
    localparam int FINE_W      = fine_w(TAP_W)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [TAP_W-1:0]    taps,
    output logic                arm,
    output logic                ts_valid,
    input  logic                ts_ready,
    output logic [COARSE_W-1:0] ts_coarse,
    output logic [FINE_W-1:0]   ts_fine,
    output logic                line_stuck
);

    localparam int DCW = $clog2(DEAD_CYCLES + 1);
    localparam int FCW = $clog2(FLUSH_MAX + 1);

    tdc_state_e          state;
    logic [COARSE_W-1:0] coarse;
    logic [COARSE_W-1:0] cap_coarse;
    logic [TAP_W-1:0]    cap_taps;
    logic                tap0_q;
    logic [DCW-1:0]      dead_cnt;
    logic [FCW-1:0]      flush_cnt;
    logic [FINE_W-1:0]   enc_fine;
    logic                line_clear;

    assign line_clear = (taps == '0);

    tdc_therm_encoder #(
        .TAP_W  (TAP_W),
        .FINE_W (FINE_W)
    ) u_enc (
        .therm (cap_taps),
        .fine  (enc_fine)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RST_STATE;
            arm        <= RST_ARM;
            ts_valid   <= RST_VALID;
            line_stuck <= RST_STUCK;
            ts_coarse  <= '0;
            ts_fine    <= '0;
            coarse     <= '0;
            cap_coarse <= '0;
            cap_taps   <= '0;
            tap0_q     <= 1'b0;
            dead_cnt   <= '0;
            flush_cnt  <= '0;
        end else begin
            tap0_q <= taps[0];
            if (enable) coarse <= coarse + 1'b1;
            // arm is registered: it is set on every transition into or stay in ARMED.
            arm <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable && line_clear) begin
                        state <= S_ARMED;
                        arm   <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (taps[0] && !tap0_q) begin
                        cap_taps   <= taps;
                        cap_coarse <= coarse;
                        state      <= S_ENCODE;
                    end else begin
                        arm <= 1'b1;
                    end
                end
                S_ENCODE: begin
                    ts_valid  <= 1'b1;
                    ts_coarse <= cap_coarse;
                    ts_fine   <= enc_fine;
                    state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (ts_ready) begin
                        ts_valid <= 1'b0;
                        dead_cnt <= '0;
                        state    <= S_DEAD;
                    end
                end
                S_DEAD: begin
                    // Last dead cycle also performs the first flush check, so a
                    // clean line re-arms DEAD_CYCLES+1 cycles after the transfer.
                    if (dead_cnt == DCW'(DEAD_CYCLES - 1)) begin
                        flush_cnt <= '0;
                        if (!enable) begin
                            state <= S_IDLE;
                        end else if (line_clear) begin
                            state <= S_ARMED;
                            arm   <= 1'b1;
                        end else begin
                            state <= S_FLUSH;
                        end
                    end else begin
                        dead_cnt <= dead_cnt + 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (line_clear) begin
                        state <= S_ARMED;
                        arm   <= 1'b1;
                    end else if (flush_cnt == FCW'(FLUSH_MAX - 1)) begin
                        // IDLE only re-arms on a clear line, which gives the retry rule.
                        line_stuck <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_hit_sequencer.sv
// tb_tdc_hit_sequencer: directed bench for tdc_hit_sequencer at default
// parameters. Inputs change and outputs are sampled 1 time unit after the
// rising edge; a small coarse-counter model supplies expected ts_coarse.
module tb_tdc_hit_sequencer;

    localparam int NCARRY4  = 8;
    localparam int TAP_W    = 32;
    localparam int FINE_W   = 6;
    localparam int COARSE_W = 16;
    localparam int DEAD     = 4;
    localparam int FMAX     = 16;
`ifdef TDC_BUBBLE_FILTER_EN
    localparam int F7_FINE  = 8;
`else
    localparam int F7_FINE  = 7;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic                enable;
    logic                ts_ready;
    logic [TAP_W-1:0]    taps;
    logic                arm;
    logic                ts_valid;
    logic [COARSE_W-1:0] ts_coarse;
    logic [FINE_W-1:0]   ts_fine;
    logic                line_stuck;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_coarse = 0;
    int exp_c;

    always #5 clk = ~clk;

    tdc_hit_sequencer #(
        .NCARRY4     (NCARRY4),
        .COARSE_W    (COARSE_W),
        .DEAD_CYCLES (DEAD),
        .FLUSH_MAX   (FMAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .taps       (taps),
        .arm        (arm),
        .ts_valid   (ts_valid),
        .ts_ready   (ts_ready),
        .ts_coarse  (ts_coarse),
        .ts_fine    (ts_fine),
        .line_stuck (line_stuck)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock; the model counts the edge if enable is high across it.
    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            if (rst_n && enable) exp_coarse = (exp_coarse + 1) % (1 << COARSE_W);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; ts_ready = 1'b0; taps = '0;
        #1;
        chk("rst_arm",    32'(arm),        0);
        chk("rst_valid",  32'(ts_valid),   0);
        chk("rst_coarse", 32'(ts_coarse),  0);
        chk("rst_fine",   32'(ts_fine),    0);
        chk("rst_stuck",  32'(line_stuck), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(2);

        // Basic hit at coarse=100, full 8-tap thermometer.
        enable = 1'b1;
        step(100);
        chk("armed", 32'(arm), 1);
        taps = 32'h0000_00FF;
        exp_c = exp_coarse;
        chk("model_c100", 32'(exp_c), 100);
        step();
        chk("enc_valid_low", 32'(ts_valid), 0);
        chk("enc_arm_low",   32'(arm),      0);
        step();
        chk("hit_valid",  32'(ts_valid),  1);
        chk("hit_coarse", 32'(ts_coarse), 32'(exp_c));
        chk("hit_fine",   32'(ts_fine),   8);

        // Back-pressure window with a second pulse on the line.
        for (int i = 0; i < 10; i++) begin
            if (i == 0) taps = '0;
            if (i == 5) taps = 32'h0000_00FF;
            chk("hold_valid",  32'(ts_valid),  1);
            chk("hold_coarse", 32'(ts_coarse), 32'(exp_c));
            chk("hold_fine",   32'(ts_fine),   8);
            chk("hold_arm",    32'(arm),       0);
            step();
        end
        ts_ready = 1'b1;
        step();
        ts_ready = 1'b0;
        chk("xfer_valid_low", 32'(ts_valid), 0);
        for (int i = 1; i <= DEAD; i++) begin
            chk("dead_arm",   32'(arm),      0);
            chk("dead_valid", 32'(ts_valid), 0);
            if (i == DEAD) taps = '0;
            step();
        end
        chk("rearm_dead_plus1", 32'(arm), 1);

        // Bubbled thermometer, handshake on the cycle valid rises.
        taps = 32'h0000_00F7;
        exp_c = exp_coarse;
        step(2);
        chk("bub_valid",  32'(ts_valid),  1);
        chk("bub_coarse", 32'(ts_coarse), 32'(exp_c));
        chk("bub_fine",   32'(ts_fine),   32'(F7_FINE));
        ts_ready = 1'b1;
        taps = 32'h0000_0001;
        step();
        ts_ready = 1'b0;
        chk("bub_xfer", 32'(ts_valid), 0);

        // Line stuck at 0x1: error after dead time plus FLUSH_MAX cycles.
        for (int i = 1; i <= DEAD + FMAX; i++) begin
            chk("stuck_arm", 32'(arm), 0);
            if (i == DEAD + FMAX) chk("stuck_early", 32'(line_stuck), 0);
            step();
        end
        chk("stuck_set", 32'(line_stuck), 1);
        for (int i = 0; i < 3; i++) begin
            chk("stuck_idle_arm", 32'(arm), 0);
            step();
        end
        taps = '0;
        step();
        chk("stuck_retry_arm", 32'(arm),        1);
        chk("stuck_sticky",    32'(line_stuck), 1);

        // enable dropped during ENCODE: timestamp still delivered, then IDLE.
        taps = 32'h0000_000F;
        exp_c = exp_coarse;
        step();
        enable = 1'b0;
        step();
        chk("dis_valid",  32'(ts_valid),  1);
        chk("dis_coarse", 32'(ts_coarse), 32'(exp_c));
        chk("dis_fine",   32'(ts_fine),   4);
        ts_ready = 1'b1;
        step();
        ts_ready = 1'b0;
        taps = '0;
        step(DEAD + 2);
        chk("dis_idle_arm",   32'(arm),      0);
        chk("dis_idle_valid", 32'(ts_valid), 0);

        // enable dropped in ARMED: IDLE on the next cycle.
        enable = 1'b1;
        step();
        chk("reen_arm", 32'(arm), 1);
        enable = 1'b0;
        step();
        chk("armed_dis_arm", 32'(arm), 0);
        enable = 1'b1;
        step();
        chk("reen2_arm", 32'(arm), 1);

        // Asynchronous reset while holding a timestamp.
        taps = 32'h0000_0003;
        step(2);
        chk("pre_rst_valid", 32'(ts_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid",  32'(ts_valid),   0);
        chk("arst_coarse", 32'(ts_coarse),  0);
        chk("arst_fine",   32'(ts_fine),    0);
        chk("arst_arm",    32'(arm),        0);
        chk("arst_stuck",  32'(line_stuck), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
